// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_DPRIO = 1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// SRAM-style bundle: fetch (I) and load/store (D) requesters plus the shared downstream port.
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic [AW-1:0] i_addr;
  logic          i_c_en;
  logic [DW-1:0] i_rdata;
  logic          i_error;
  logic          i_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_c_en;
  logic          d_w_en;
  logic [3:0]    d_b_en;
  logic [DW-1:0] d_rdata;
  logic          d_error;
  logic          d_stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_c_en;
  logic          m_w_en;
  logic [3:0]    m_b_en;
  logic [DW-1:0] m_rdata;
  logic          m_error;
  logic          m_stall;

  modport slave (
    input  i_addr, i_c_en, output i_rdata, i_error, i_stall,
    input  d_addr, d_wdata, d_c_en, d_w_en, d_b_en,
    output d_rdata, d_error, d_stall,
    output m_addr, m_wdata, m_c_en, m_w_en, m_b_en,
    input  m_rdata, m_error, m_stall
  );

  modport master (
    output i_addr, i_c_en, input i_rdata, i_error, i_stall,
    output d_addr, d_wdata, d_c_en, d_w_en, d_b_en,
    input  d_rdata, d_error, d_stall,
    input  m_addr, m_wdata, m_c_en, m_w_en, m_b_en,
    output m_rdata, m_error, m_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Grants the single downstream port to I or D, one transaction at a time, via a registered
// IDLE/OWN_I/OWN_D FSM; every grant is followed by at least one IDLE arbitration cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input logic               ACLK,
  input logic               ARESETn,
  mem_port_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       served_q, served_d;
  logic       own_i, own_d, done, tie_d, pick_d;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      served_q <= served_d;
    end
  end

  // Ties: fixed mode always picks D. Round-robin picks whoever was not served last,
  // with I winning until the first completion after reset (served_q still clear).
  assign tie_d  = (ARB_MODE == ARB_DPRIO) || (served_q && !last_d_q);
  assign pick_d = bus.d_c_en && (!bus.i_c_en || tie_d);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    served_d = served_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.i_c_en || bus.d_c_en) state_d = pick_d ? ARB_OWN_D : ARB_OWN_I;
      end
      ARB_OWN_I: begin
        if (!bus.m_stall) begin
          state_d  = ARB_IDLE;
          last_d_d = 1'b0;
          served_d = 1'b1;
        end
      end
      ARB_OWN_D: begin
        if (!bus.m_stall) begin
          state_d  = ARB_IDLE;
          last_d_d = 1'b1;
          served_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign own_i = (state_q == ARB_OWN_I);
  assign own_d = (state_q == ARB_OWN_D);
  assign done  = !bus.m_stall;

  // Fetches are always full-word reads.
  assign bus.m_c_en  = own_i || own_d;
  assign bus.m_addr  = own_d ? bus.d_addr : (own_i ? bus.i_addr : {AW{1'b0}});
  assign bus.m_wdata = own_d ? bus.d_wdata : {DW{1'b0}};
  assign bus.m_w_en  = own_d && bus.d_w_en;
  assign bus.m_b_en  = own_d ? bus.d_b_en : (own_i ? 4'hF : 4'h0);

  assign bus.i_rdata = own_i ? bus.m_rdata : {DW{1'b0}};
  assign bus.d_rdata = own_d ? bus.m_rdata : {DW{1'b0}};
  assign bus.i_error = own_i && done && bus.m_error;
  assign bus.d_error = own_d && done && bus.m_error;
  assign bus.i_stall = bus.i_c_en && !(own_i && done);
  assign bus.d_stall = bus.d_c_en && !(own_d && done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin (dut 0) and a D-priority (dut 1) arbiter and checks every output each
// cycle against a transaction-level model of who owns the port.
module tb_mem_port_arbiter;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        i_cen[2], d_cen[2], d_wen[2], m_stall[2], m_err[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2], m_rdata[2];
  logic [3:0]  d_ben[2];
  logic [31:0] o_irdata[2], o_drdata[2], o_maddr[2], o_mwdata[2];
  logic        o_ierr[2], o_istall[2], o_derr[2], o_dstall[2], o_mcen[2], o_mwen[2];
  logic [3:0]  o_mben[2];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_dut
      mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
      assign bus.i_addr  = i_addr[k];
      assign bus.i_c_en  = i_cen[k];
      assign bus.d_addr  = d_addr[k];
      assign bus.d_wdata = d_wdata[k];
      assign bus.d_c_en  = d_cen[k];
      assign bus.d_w_en  = d_wen[k];
      assign bus.d_b_en  = d_ben[k];
      assign bus.m_rdata = m_rdata[k];
      assign bus.m_error = m_err[k];
      assign bus.m_stall = m_stall[k];
      assign o_irdata[k] = bus.i_rdata;
      assign o_ierr[k]   = bus.i_error;
      assign o_istall[k] = bus.i_stall;
      assign o_drdata[k] = bus.d_rdata;
      assign o_derr[k]   = bus.d_error;
      assign o_dstall[k] = bus.d_stall;
      assign o_maddr[k]  = bus.m_addr;
      assign o_mwdata[k] = bus.m_wdata;
      assign o_mcen[k]   = bus.m_c_en;
      assign o_mwen[k]   = bus.m_w_en;
      assign o_mben[k]   = bus.m_b_en;
      mem_port_arbiter #(.ARB_MODE(k), .AW(32), .DW(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
      );
    end
  endgenerate

  // Model: owner 0=none 1=I 2=D; last_srv is the requester that completed most recently.
  int own[2], last_srv[2], n_i[2], n_d[2];
  int errors = 0, checks = 0, cur_k = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  task automatic settle_check();
    #1;
    for (int k = 0; k < 2; k++) begin
      logic ci, cd;
      cur_k = k;
      if (!ARESETn) begin own[k] = 0; last_srv[k] = 0; end
      ci = (own[k] == 1) && !m_stall[k];
      cd = (own[k] == 2) && !m_stall[k];
      chk("m_c_en",  64'(o_mcen[k]), 64'(own[k] != 0));
      chk("m_addr",  64'(o_maddr[k]), own[k] == 1 ? 64'(i_addr[k]) : own[k] == 2 ? 64'(d_addr[k]) : 64'd0);
      chk("m_wdata", 64'(o_mwdata[k]), own[k] == 2 ? 64'(d_wdata[k]) : 64'd0);
      chk("m_w_en",  64'(o_mwen[k]), 64'(own[k] == 2 && d_wen[k]));
      chk("m_b_en",  64'(o_mben[k]), own[k] == 1 ? 64'hF : own[k] == 2 ? 64'(d_ben[k]) : 64'd0);
      chk("i_stall", 64'(o_istall[k]), 64'(i_cen[k] && !ci));
      chk("d_stall", 64'(o_dstall[k]), 64'(d_cen[k] && !cd));
      chk("i_rdata", 64'(o_irdata[k]), own[k] == 1 ? 64'(m_rdata[k]) : 64'd0);
      chk("d_rdata", 64'(o_drdata[k]), own[k] == 2 ? 64'(m_rdata[k]) : 64'd0);
      chk("i_error", 64'(o_ierr[k]), 64'(ci && m_err[k]));
      chk("d_error", 64'(o_derr[k]), 64'(cd && m_err[k]));
    end
  endtask

  // Apply the clock edge to the model, retire completed requests, move to the next negedge.
  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (ARESETn) begin
        if (own[k] != 0) begin
          if (!m_stall[k]) begin last_srv[k] = own[k]; own[k] = 0; end
        end else if (i_cen[k] && d_cen[k]) begin
          own[k] = (k == 1) ? 2 : (last_srv[k] == 1 ? 2 : 1);
        end else if (i_cen[k] || d_cen[k]) begin
          own[k] = i_cen[k] ? 1 : 2;
        end
      end
      if (i_cen[k] && !o_istall[k]) begin n_i[k]++; i_cen[k] = 1'b0; end
      if (d_cen[k] && !o_dstall[k]) begin n_d[k]++; d_cen[k] = 1'b0; end
    end
    @(negedge ACLK);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic set_i(input logic c, input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin i_cen[k] = c; i_addr[k] = a; end
  endtask

  task automatic set_d(input logic c, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    for (int k = 0; k < 2; k++) begin
      d_cen[k] = c; d_wen[k] = w; d_addr[k] = a; d_wdata[k] = wd; d_ben[k] = be;
    end
  endtask

  task automatic set_m(input logic s, input logic [31:0] rd, input logic e);
    for (int k = 0; k < 2; k++) begin m_stall[k] = s; m_rdata[k] = rd; m_err[k] = e; end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin own[k] = 0; last_srv[k] = 0; n_i[k] = 0; n_d[k] = 0; end
    set_i(1'b1, 32'h0); set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); set_m(1'b1, 32'hA5A5A5A5, 1'b1);
    @(negedge ACLK);
    step();                                  // in reset: idle outputs, stall mirrors c_en
    set_i(1'b0, 32'h0);
    ARESETn = 1'b1;

    // single fetch
    set_i(1'b1, 32'h100); set_m(1'b0, 32'hDEADBEEF, 1'b0);
    settle_check(); cur_k = 0; chk("fetch_arb_cen", 64'(o_mcen[0]), 64'd0); advance();
    settle_check(); cur_k = 0;
    chk("fetch_stall", 64'(o_istall[0]), 64'd0);
    chk("fetch_rdata", 64'(o_irdata[0]), 64'hDEADBEEF);
    advance();
    settle_check(); cur_k = 0; chk("fetch_idle", 64'(o_mcen[0]), 64'd0); advance();

    // stalled write: 5 stalled owned cycles, completion on the 6th
    set_d(1'b1, 1'b1, 32'h2000, 32'h12345678, 4'b0011); set_m(1'b1, 32'h0, 1'b0);
    step();
    repeat (5) begin
      settle_check(); cur_k = 1;
      chk("sw_addr", 64'(o_maddr[1]), 64'h2000);
      chk("sw_stall", 64'(o_dstall[1]), 64'd1);
      advance();
    end
    set_m(1'b0, 32'h0, 1'b0);
    settle_check(); cur_k = 1; chk("sw_done", 64'(o_dstall[1]), 64'd0); advance();

    // read error: exactly one cycle of d_error, none on I (error in IDLE is ignored)
    set_d(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF); set_m(1'b0, 32'h5555, 1'b1);
    step();
    settle_check(); cur_k = 0;
    chk("err_d", 64'(o_derr[0]), 64'd1);
    chk("err_i", 64'(o_ierr[0]), 64'd0);
    advance();
    settle_check(); cur_k = 0; chk("err_once", 64'(o_derr[0]), 64'd0); advance();

    // reset while D owns a stalled transaction
    set_d(1'b1, 1'b0, 32'h4000, 32'h0, 4'hF); set_m(1'b1, 32'h0, 1'b0);
    step(); step();
    ARESETn = 1'b0; set_i(1'b1, 32'h500);
    settle_check();
    for (int k = 0; k < 2; k++) begin cur_k = k; chk("rst_drop", 64'(o_mcen[k]), 64'd0); end
    advance();
    ARESETn = 1'b1; set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    set_m(1'b0, 32'h77, 1'b0);
    settle_check();
    for (int k = 0; k < 2; k++) begin cur_k = k; chk("rst_grant_i", 64'(o_maddr[k]), 64'h500); end
    advance();

    // continuous tie from reset: RR alternates I,D,...; D-priority never serves I
    set_i(1'b0, 32'h600); set_d(1'b0, 1'b0, 32'h700, 32'h0, 4'hF);
    ARESETn = 1'b0; step(); ARESETn = 1'b1;
    set_m(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin n_i[k] = 0; n_d[k] = 0; end
    repeat (12) begin
      for (int k = 0; k < 2; k++) begin i_cen[k] = 1'b1; d_cen[k] = 1'b1; end
      step();
    end
    cur_k = 0; chk("rr_i_cnt", 64'(n_i[0]), 64'd3); chk("rr_d_cnt", 64'(n_d[0]), 64'd3);
    cur_k = 1; chk("dp_i_cnt", 64'(n_i[1]), 64'd0); chk("dp_d_cnt", 64'(n_d[1]), 64'd6);
    set_i(1'b0, 32'h0); set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // random traffic; requesters hold their request until completion
    repeat (1500) begin
      for (int k = 0; k < 2; k++) begin
        if (!i_cen[k]) begin i_cen[k] = ($urandom_range(0, 1) == 1); i_addr[k] = $urandom; end
        if (!d_cen[k]) begin
          d_cen[k] = ($urandom_range(0, 1) == 1); d_wen[k] = ($urandom_range(0, 1) == 1);
          d_addr[k] = $urandom; d_wdata[k] = $urandom; d_ben[k] = 4'($urandom);
        end
        m_stall[k] = ($urandom_range(0, 2) == 0);
        m_rdata[k] = $urandom;
        m_err[k]   = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
